// File: rtl/light_show_pwm_engine.sv
// light_show_pwm_engine: NUM_CH RGB LED PWM driver with a period-synchronous
// pattern engine. Define LSC_GAMMA_EN for a squared-law BREATHE duty curve.
module light_show_pwm_engine #(
    parameter int NUM_CH        = 4,
    parameter int PWM_BITS      = 8,
    parameter int STEP_DIV_SLOW = 64,
    parameter int STEP_DIV_FAST = 16,
    parameter int BREATHE_STEP  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          color_switch,
    input  logic                speed_switch,
    input  logic [1:0]          pattern_sel,
    input  logic                enable,
    output logic [3*NUM_CH-1:0] pwm_out,
    output logic                step_tick
);

    typedef enum logic [1:0] {
        PAT_STATIC  = 2'b00,
        PAT_BLINK   = 2'b01,
        PAT_CHASE   = 2'b10,
        PAT_BREATHE = 2'b11
    } pat_e;

    localparam int DIV_MAX = (STEP_DIV_SLOW > STEP_DIV_FAST) ?
                             STEP_DIV_SLOW : STEP_DIV_FAST;
    localparam int SW = $clog2(DIV_MAX + 1);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [PWM_BITS-1:0] FULL     = '1;
    localparam logic [PWM_BITS:0]   FULL_X   = {1'b0, FULL};
    localparam logic [PWM_BITS:0]   BSTEP    = (PWM_BITS+1)'(BREATHE_STEP);
    localparam logic [SW-1:0]       LIM_SLOW = SW'(STEP_DIV_SLOW - 1);
    localparam logic [SW-1:0]       LIM_FAST = SW'(STEP_DIV_FAST - 1);
    localparam logic [PW-1:0]       POS_LAST = PW'(NUM_CH - 1);

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [SW-1:0]       step_cnt_q, step_cnt_d;
    pat_e                pat_q, pat_d;
    logic [2:0]          col_q, col_d;
    logic [PW-1:0]       pos_q, pos_d;
    logic [PWM_BITS-1:0] lvl_q, lvl_d;
    logic                dir_dn_q, dir_dn_d;
    logic                blink_on_q, blink_on_d;
    logic [3*NUM_CH-1:0] pwm_out_q, pwm_out_d;
    logic                tick_q, tick_d;

    logic                boundary;
    logic                tick_now;
    logic                pat_change;
    logic [SW-1:0]       div_lim;
    logic [PWM_BITS:0]   lvl_up;
    logic [PWM_BITS:0]   lvl_dn;
    logic [PWM_BITS-1:0] brth_duty;
    logic [PWM_BITS-1:0] ch_lvl;
    logic [PWM_BITS-1:0] duty;

`ifdef LSC_GAMMA_EN
    localparam int W2 = 2 * PWM_BITS;
    // Squared-law curve keeps full-on exactly full-on.
    assign brth_duty = (lvl_q == FULL) ? FULL :
        PWM_BITS'((W2'(lvl_q) * W2'(lvl_q)) >> PWM_BITS);
`else
    assign brth_duty = lvl_q;
`endif

    // State register: counters, latched user inputs, phase and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            pat_q      <= PAT_STATIC;
            col_q      <= '0;
            pos_q      <= '0;
            lvl_q      <= '0;
            dir_dn_q   <= 1'b0;
            blink_on_q <= 1'b1;
            pwm_out_q  <= '0;
            tick_q     <= 1'b0;
        end else begin
            pwm_cnt_q  <= pwm_cnt_d;
            step_cnt_q <= step_cnt_d;
            pat_q      <= pat_d;
            col_q      <= col_d;
            pos_q      <= pos_d;
            lvl_q      <= lvl_d;
            dir_dn_q   <= dir_dn_d;
            blink_on_q <= blink_on_d;
            pwm_out_q  <= pwm_out_d;
            tick_q     <= tick_d;
        end
    end

    // Next state: inputs only take effect at the end of a PWM period.
    always_comb begin
        boundary   = (pwm_cnt_q == FULL);
        div_lim    = speed_switch ? LIM_FAST : LIM_SLOW;
        tick_now   = boundary && (step_cnt_q >= div_lim);
        pat_change = (pattern_sel != pat_q);
        lvl_up     = {1'b0, lvl_q} + BSTEP;
        lvl_dn     = {1'b0, lvl_q} - BSTEP;

        pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
        step_cnt_d = step_cnt_q;
        pat_d      = pat_q;
        col_d      = col_q;
        pos_d      = pos_q;
        lvl_d      = lvl_q;
        dir_dn_d   = dir_dn_q;
        blink_on_d = blink_on_q;
        tick_d     = 1'b0;

        if (!enable) begin
            pwm_cnt_d  = '0;
            step_cnt_d = '0;
            pos_d      = '0;
            lvl_d      = '0;
            dir_dn_d   = 1'b0;
            blink_on_d = 1'b1;
        end else if (boundary) begin
            col_d      = color_switch;
            pat_d      = pat_e'(pattern_sel);
            tick_d     = tick_now;
            step_cnt_d = tick_now ? '0 : step_cnt_q + SW'(1);
            // A new pattern always starts from its initial phase.
            if (pat_change) begin
                pos_d      = '0;
                lvl_d      = '0;
                dir_dn_d   = 1'b0;
                blink_on_d = 1'b1;
            end else if (tick_now) begin
                case (pat_q)
                    PAT_STATIC: ;
                    PAT_BLINK:  blink_on_d = !blink_on_q;
                    PAT_CHASE:  pos_d = (pos_q == POS_LAST) ?
                                        '0 : pos_q + PW'(1);
                    PAT_BREATHE: begin
                        if (!dir_dn_q) begin
                            if (lvl_up >= FULL_X) begin
                                lvl_d    = FULL;
                                dir_dn_d = 1'b1;
                            end else begin
                                lvl_d = lvl_up[PWM_BITS-1:0];
                            end
                        end else begin
                            if (lvl_dn[PWM_BITS] || lvl_dn == '0) begin
                                lvl_d    = '0;
                                dir_dn_d = 1'b0;
                            end else begin
                                lvl_d = lvl_dn[PWM_BITS-1:0];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output decode: per-channel level, colour mask, PWM compare.
    always_comb begin
        pwm_out_d = '0;
        ch_lvl    = '0;
        duty      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (pat_q)
                PAT_STATIC:  ch_lvl = FULL;
                PAT_BLINK:   ch_lvl = blink_on_q ? FULL : '0;
                PAT_CHASE:   ch_lvl = (pos_q == PW'(i)) ? FULL : '0;
                PAT_BREATHE: ch_lvl = brth_duty;
                default:     ch_lvl = '0;
            endcase
            for (int c = 0; c < 3; c++) begin
                duty = col_q[c] ? ch_lvl : '0;
                pwm_out_d[3*i+c] = enable &&
                    ((duty == FULL) || (pwm_cnt_q < duty));
            end
        end
    end

    assign pwm_out   = pwm_out_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_light_show_pwm_engine.sv
// tb_light_show_pwm_engine: scenario tasks plus a behavioural reference
// model of the pattern engine, with randomized input sequences.
module tb_light_show_pwm_engine;

    localparam int NCH  = 4;
    localparam int PB   = 4;
    localparam int SLOW = 4;
    localparam int FAST = 2;
    localparam int BST  = 4;
    localparam int MAXV = (1 << PB) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       color_switch = '0;
    logic             speed_switch = 1'b0;
    logic [1:0]       pattern_sel = '0;
    logic             enable = 1'b1;
    logic [3*NCH-1:0] pwm_out;
    logic             step_tick;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    light_show_pwm_engine #(
        .NUM_CH       (NCH),
        .PWM_BITS     (PB),
        .STEP_DIV_SLOW(SLOW),
        .STEP_DIV_FAST(FAST),
        .BREATHE_STEP (BST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .color_switch(color_switch),
        .speed_switch(speed_switch),
        .pattern_sel (pattern_sel),
        .enable      (enable),
        .pwm_out     (pwm_out),
        .step_tick   (step_tick)
    );

    // Reference model state, in plain integers.
    int               m_cnt  = 0;
    int               m_step = 0;
    int               m_pat  = 0;
    logic [2:0]       m_col  = '0;
    int               m_pos  = 0;
    int               m_lvl  = 0;
    bit               m_up   = 1'b1;
    bit               m_on   = 1'b1;
    logic [3*NCH-1:0] exp_out  = '0;
    logic             exp_tick = 1'b0;

    function automatic int chan_level(int i);
        int v;
        case (m_pat)
            0: v = MAXV;
            1: v = m_on ? MAXV : 0;
            2: v = (i == m_pos) ? MAXV : 0;
            default: begin
`ifdef LSC_GAMMA_EN
                v = (m_lvl == MAXV) ? MAXV : (m_lvl * m_lvl) / (MAXV + 1);
`else
                v = m_lvl;
`endif
            end
        endcase
        return v;
    endfunction

    function automatic logic [3*NCH-1:0] model_out();
        logic [3*NCH-1:0] o;
        int d;
        o = '0;
        for (int i = 0; i < NCH; i++) begin
            for (int c = 0; c < 3; c++) begin
                d = m_col[c] ? chan_level(i) : 0;
                o[3*i+c] = (d == MAXV) || (m_cnt < d);
            end
        end
        return o;
    endfunction

    function automatic int brth_next(int l, bit up);
        int n;
        n = up ? l + BST : l - BST;
        if (n >= MAXV) return MAXV;
        if (n <= 0) return 0;
        return n;
    endfunction

    function automatic bit brth_dir(int l, bit up);
        int n;
        n = up ? l + BST : l - BST;
        if (n >= MAXV) return 1'b0;
        if (n <= 0) return 1'b1;
        return up;
    endfunction

    function automatic bit model_hit();
        int lim;
        lim = speed_switch ? FAST : SLOW;
        return m_step >= lim - 1;
    endfunction

    // Reference model: what the LEDs should show on the next cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; m_step <= 0; m_pat <= 0; m_col <= '0;
            m_pos <= 0; m_lvl <= 0; m_up <= 1'b1; m_on <= 1'b1;
            exp_out <= '0; exp_tick <= 1'b0;
        end else if (!enable) begin
            m_cnt <= 0; m_step <= 0;
            m_pos <= 0; m_lvl <= 0; m_up <= 1'b1; m_on <= 1'b1;
            exp_out <= '0; exp_tick <= 1'b0;
        end else begin
            exp_out  <= model_out();
            exp_tick <= 1'b0;
            m_cnt    <= (m_cnt + 1) % (MAXV + 1);
            if (m_cnt == MAXV) begin
                exp_tick <= model_hit();
                m_step   <= model_hit() ? 0 : m_step + 1;
                m_pat    <= int'(pattern_sel);
                m_col    <= color_switch;
                if (int'(pattern_sel) != m_pat) begin
                    m_pos <= 0; m_lvl <= 0; m_up <= 1'b1; m_on <= 1'b1;
                end else if (model_hit()) begin
                    case (m_pat)
                        1: m_on <= !m_on;
                        2: m_pos <= (m_pos + 1) % NCH;
                        3: begin
                            m_lvl <= brth_next(m_lvl, m_up);
                            m_up  <= brth_dir(m_lvl, m_up);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    task automatic sync_tick(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            ok = step_tick;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        enable = 1'b1;
        color_switch = 3'b001;
        pattern_sel = 2'b00;
        speed_switch = 1'b0;
        #1 rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (pwm_out !== '0 || step_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset out=%h tick=%b want out=0 tick=0",
                         pwm_out, step_tick);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_static();
        for (int k = 1; k <= 140; k++) begin
            @(negedge clk);
            vectors++;
            if (pwm_out !== exp_out || step_tick !== exp_tick) begin
                errors++;
                $display("FAIL static_model k=%0d out=%h/%b want %h/%b",
                         k, pwm_out, step_tick, exp_out, exp_tick);
            end
            vectors++;
            if (step_tick !== (k % 64 == 0)) begin
                errors++;
                $display("FAIL static_tick k=%0d tick=%b want %b",
                         k, step_tick, (k % 64 == 0));
            end
            if (k == 10 || k == 17 || k == 100) begin
                vectors++;
                if (pwm_out !== ((k < 17) ? 12'h000 : 12'h249)) begin
                    errors++;
                    $display("FAIL static_out k=%0d out=%h want %h", k,
                             pwm_out, (k < 17) ? 12'h000 : 12'h249);
                end
            end
        end
    endtask

    task automatic test_blink();
        int exp_gap[5] = '{64, 64, 48, 32, 32};
        int since = 0;
        int k = 0;
        bit ok;
        sync_tick(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL blink_sync got=no_tick want=tick");
            return;
        end
        pattern_sel = 2'b01;
        color_switch = 3'b001;
        speed_switch = 1'b0;
        for (int c = 0; c < 600 && k < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (pwm_out !== exp_out || step_tick !== exp_tick) begin
                errors++;
                $display("FAIL blink_model out=%h/%b want %h/%b",
                         pwm_out, step_tick, exp_out, exp_tick);
            end
            since++;
            if (step_tick) begin
                vectors++;
                if (since != exp_gap[k]) begin
                    errors++;
                    $display("FAIL blink_gap%0d got=%0d want=%0d",
                             k, since, exp_gap[k]);
                end
                k++;
                since = 0;
            end
            if (k == 2 && since == 40) speed_switch = 1'b1;
        end
        vectors++;
        if (k < 5) begin
            errors++;
            $display("FAIL blink_timeout ticks=%0d want=5", k);
        end
    endtask

    task automatic test_chase();
        int want_pos[5] = '{0, 1, 2, 3, 0};
        int since = 0;
        int tk = 0;
        int n = 0;
        logic [3*NCH-1:0] want;
        bit ok;
        speed_switch = 1'b1;
        sync_tick(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL chase_sync got=no_tick want=tick");
            return;
        end
        pattern_sel = 2'b10;
        color_switch = 3'b111;
        for (int c = 0; c < 400 && n < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (pwm_out !== exp_out || step_tick !== exp_tick) begin
                errors++;
                $display("FAIL chase_model out=%h/%b want %h/%b",
                         pwm_out, step_tick, exp_out, exp_tick);
            end
            if (step_tick) begin
                since = 0;
                tk++;
            end else begin
                since++;
            end
            if ((tk == 0 && n == 0 && since == 24) ||
                (tk > 0 && tk == n && since == 8)) begin
                want = 12'h007 << (3 * want_pos[n]);
                vectors++;
                if (pwm_out !== want) begin
                    errors++;
                    $display("FAIL chase_pos%0d out=%h want %h",
                             n, pwm_out, want);
                end
                n++;
            end
        end
        vectors++;
        if (n < 5) begin
            errors++;
            $display("FAIL chase_timeout samples=%0d want=5", n);
        end
    endtask

    task automatic test_breathe();
        int lv[9] = '{4, 8, 12, 15, 11, 7, 3, 0, 4};
        int since = 0;
        int tk = 0;
        int hi = 0;
        int done = 0;
        int e;
        bit ok;
        speed_switch = 1'b1;
        sync_tick(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL breathe_sync got=no_tick want=tick");
            return;
        end
        pattern_sel = 2'b11;
        color_switch = 3'b010;
        for (int c = 0; c < 600 && done < 9; c++) begin
            @(negedge clk);
            vectors++;
            if (pwm_out !== exp_out || step_tick !== exp_tick) begin
                errors++;
                $display("FAIL breathe_model out=%h/%b want %h/%b",
                         pwm_out, step_tick, exp_out, exp_tick);
            end
            if (step_tick) begin
                since = 0;
                hi = 0;
                tk++;
            end else begin
                since++;
                if (tk > 0 && since <= 16) hi += int'(pwm_out[1]);
                if (tk > 0 && since == 16 && done < 9) begin
`ifdef LSC_GAMMA_EN
                    e = (lv[done] == MAXV) ? MAXV : lv[done] * lv[done] / 16;
`else
                    e = lv[done];
`endif
                    if (e == MAXV) e = 16;
                    vectors++;
                    if (hi != e) begin
                        errors++;
                        $display("FAIL breathe_duty lvl=%0d high=%0d want=%0d",
                                 lv[done], hi, e);
                    end
                    done++;
                end
            end
        end
        vectors++;
        if (done < 9) begin
            errors++;
            $display("FAIL breathe_timeout periods=%0d want=9", done);
        end
    endtask

    task automatic test_color_change();
        bit ok;
        logic [3*NCH-1:0] want;
        pattern_sel = 2'b00;
        color_switch = 3'b001;
        speed_switch = 1'b1;
        sync_tick(ok);
        if (ok) sync_tick(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL color_sync got=no_tick want=tick");
            return;
        end
        repeat (5) @(negedge clk);
        color_switch = 3'b100;
        for (int s = 6; s <= 20; s++) begin
            @(negedge clk);
            want = (s <= 16) ? 12'h249 : 12'h924;
            vectors++;
            if (pwm_out !== want) begin
                errors++;
                $display("FAIL color_change s=%0d out=%h want %h",
                         s, pwm_out, want);
            end
        end
    endtask

    task automatic test_async_reset();
        bit ok;
        speed_switch = 1'b1;
        sync_tick(ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL arst_sync got=no_tick want=tick");
            return;
        end
        pattern_sel = 2'b10;
        color_switch = 3'b111;
        for (int k = 0; k < 72; k++) begin
            @(negedge clk);
            vectors++;
            if (pwm_out !== exp_out || step_tick !== exp_tick) begin
                errors++;
                $display("FAIL arst_model out=%h/%b want %h/%b",
                         pwm_out, step_tick, exp_out, exp_tick);
            end
        end
        vectors++;
        if (pwm_out !== 12'h1C0) begin
            errors++;
            $display("FAIL arst_pos2 out=%h want 1c0", pwm_out);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (pwm_out !== '0 || step_tick !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate out=%h tick=%b want 0/0",
                     pwm_out, step_tick);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            vectors++;
            if (pwm_out !== exp_out || step_tick !== exp_tick) begin
                errors++;
                $display("FAIL arst_restart_model k=%0d out=%h/%b want %h/%b",
                         k, pwm_out, step_tick, exp_out, exp_tick);
            end
            if (k == 10 || k == 20) begin
                vectors++;
                if (pwm_out !== ((k == 10) ? 12'h000 : 12'h007)) begin
                    errors++;
                    $display("FAIL arst_restart k=%0d out=%h want %h", k,
                             pwm_out, (k == 10) ? 12'h000 : 12'h007);
                end
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            vectors++;
            if (pwm_out !== exp_out || step_tick !== exp_tick) begin
                errors++;
                $display("FAIL random_model c=%0d out=%h/%b want %h/%b",
                         c, pwm_out, step_tick, exp_out, exp_tick);
            end
            if (hold == 0) begin
                hold = $urandom_range(1, 160);
                color_switch = 3'($urandom);
                pattern_sel = 2'($urandom);
                speed_switch = 1'($urandom);
                enable = ($urandom_range(0, 7) != 0);
            end else begin
                hold--;
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_static();
        test_blink();
        test_chase();
        test_breathe();
        test_color_change();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/light_show_pwm_engine.md
Name: light_show_pwm_engine

Overview:
Clocked, parametrised successor to the light show controller. Drives NUM_CH RGB LEDs with true PWM, using a period-synchronous pattern state machine (static, blink, chase, breathe) paced by a selectable step divider. Sits between the board switches and the LED pins. All user inputs are sampled only at PWM period boundaries, so outputs never glitch mid-period.

Parameters:
NUM_CH, 4, number of RGB LEDs driven
PWM_BITS, 8, PWM counter/duty width; period = 2^PWM_BITS clocks
STEP_DIV_SLOW, 64, PWM periods per pattern step when speed_switch=0 (>=1)
STEP_DIV_FAST, 16, PWM periods per pattern step when speed_switch=1 (>=1)
BREATHE_STEP, 8, duty increment/decrement per step in BREATHE (1..2^PWM_BITS-1)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
color_switch  input  3  colour enable; bit0=R, bit1=G, bit2=B
speed_switch  input  1  0=slow step rate, 1=fast step rate
pattern_sel  input  2  00=STATIC, 01=BLINK, 10=CHASE, 11=BREATHE
enable  input  1  0 forces all outputs off and holds engine in initial phase
pwm_out  output  3*NUM_CH  LED drive; channel i at bits [3i+2:3i] = {B,G,R}
step_tick  output  1  one-cycle pulse on each pattern step

Behaviour:
- Reset: pwm_out=0, step_tick=0, pwm_cnt=0, step_cnt=0, latched pattern=STATIC, colour shadow=000, chase pos=0, breathe level=0, breathe dir=up, blink phase=on.
- pwm_cnt: free-running, PWM_BITS wide, wraps 2^PWM_BITS-1 -> 0. Boundary = cycle where pwm_cnt==all-ones.
- At each boundary: latch color_switch into the colour shadow and pattern_sel into the pattern register, and advance step_cnt.
- If the latched pattern changes, reset phase state (pos=0, level=0, dir=up, blink on) at that boundary.
- step_cnt: div = speed_switch ? STEP_DIV_FAST : STEP_DIV_SLOW, sampled at the boundary. When step_cnt >= div-1 at a boundary: step_cnt<=0, step_tick=1 for exactly that one cycle, and the pattern advances.
  - The >= compare means a slow-to-fast switch with step_cnt beyond the new limit ticks at the next boundary.
- Per-channel duty level L_i (PWM_BITS):
  - STATIC: all L_i = all-ones.
  - BLINK: phase toggles each tick; L_i = all-ones when on, 0 when off.
  - CHASE: L_pos = all-ones, all others 0; pos increments each tick and wraps NUM_CH-1 -> 0.
  - BREATHE: all L_i = level. On each tick, level += BREATHE_STEP when dir=up, or -= BREATHE_STEP when down. Compute in PWM_BITS+1 bits. Saturate at all-ones, then set dir=down; saturate at 0, then set dir=up.
- Duty per colour bit c of channel i: D = colour_shadow[c] ? L_i : 0.
- Output bit = (D==all-ones) | (pwm_cnt < D), registered. This gives one cycle of latency from pwm_cnt. Full-on is 100%; duty 0 is never high.
- New levels take effect on the first cycle of the next period, i.e. pwm_cnt==0.
- enable=0, sampled every cycle:
  - next cycle: pwm_out=0, step_tick=0;
  - pwm_cnt and step_cnt held at 0; phase state reset as on pattern change.
  - On re-enable, counting resumes from pwm_cnt=0. The first boundary latches the inputs.
- Async reset mid-operation: all outputs go to 0 immediately (not clock-aligned). Behaviour restarts exactly as from power-on.
- colour_shadow=000: all outputs 0 regardless of pattern; the pattern FSM still advances.

Optional Feature:
LSC_GAMMA_EN — when defined, BREATHE duty passes through an approximate gamma: D_eff = (level*level) >> PWM_BITS, with all-ones mapped to all-ones. When undefined, BREATHE duty is linear (D_eff = level). STATIC, BLINK and CHASE are unaffected in both builds.

Test Plan:
Bench parameters: NUM_CH=4, PWM_BITS=4, STEP_DIV_SLOW=4, STEP_DIV_FAST=2, BREATHE_STEP=4, enable=1.
1. Reset then color=001, pattern=00 -> after first boundary (clock 16), all R bits constantly 1, all G/B bits 0; step_tick every 64 clocks.
2. pattern=01, speed=0 -> R of all channels toggles every 64 clocks. Set speed=1 -> toggles every 32 clocks, with step_tick pulses 32 clocks apart.
3. pattern=10, color=111 -> channel 0 white for one step, then 1, 2, 3, then back to 0 on the 4th tick; others 0.
4. pattern=11, color=010, linear build -> level sequence 0,4,8,12,15,11,7,3,0,4. At level 4, G is high for exactly 4 of 16 clocks per period. Gamma build: level 8 gives 4 clocks high.
5. Change color 001 -> 100 at pwm_cnt=5 -> pwm_out unchanged until cycle after pwm_cnt wraps to 0, then B active and R off.
6. Assert rst asynchronously during CHASE pos=2 -> pwm_out=0 within same cycle. After release, pattern=10 is latched at the first boundary and chase restarts at pos 0.
